dma_address_count_unit: RTL

Per-channel address and word-count datapath of the DMA controller. It holds the base and current address and word-count registers for every channel and is programmed by the CPU through the 8-bit data bus using a byte-pointer flip-flop. During transfers it advances the serviced channel's address and count and detects Terminal Count (TC). It reloads the channel on autoinitialization and maintains the TC half of the status register. It sits between the CPU register interface and the timing/control FSM, which supplies the transfer step strobes and consumes the address and TC outputs.

---
 rtl/dma_address_count_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dma_address_count_unit.sv
// Per-channel DMA base/current address and word-count registers, CPU byte-pointer access, TC detection.
// dataOut, tcPulse and tcChannel are registered; currentAddressOut is a combinational mux on xferChannel.
module dma_address_count_unit #(
  parameter int CHANNELS     = 4,
  parameter int ADDRESSWIDTH = 16,
  parameter int DATAWIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    cpuWrite,
  input  logic                    cpuRead,
  input  logic [3:0]              cpuAddr,
  input  logic [DATAWIDTH-1:0]    dataIn,
  output logic [DATAWIDTH-1:0]    dataOut,
  input  logic [CHANNELS-1:0]     dreqStatus,
  input  logic [CHANNELS-1:0]     addrDecrement,
  input  logic [CHANNELS-1:0]     autoinit,
  input  logic                    xferStep,
  input  logic [1:0]              xferChannel,
  output logic [ADDRESSWIDTH-1:0] currentAddressOut,
  output logic                    tcPulse,
  output logic [1:0]              tcChannel,
  output logic [CHANNELS-1:0]     statusTC
);

  localparam int HI = ADDRESSWIDTH - DATAWIDTH;
  localparam logic [ADDRESSWIDTH-1:0] ONE = ADDRESSWIDTH'(1);
  localparam logic [3:0] ADDR_STATUS     = 4'd8;
  localparam logic [3:0] ADDR_CLR_PTR    = 4'd12;
  localparam logic [3:0] ADDR_MASTER_CLR = 4'd13;

  typedef logic [ADDRESSWIDTH-1:0] word_t;

  word_t base_addr_q [CHANNELS];
  word_t base_addr_d [CHANNELS];
  word_t cur_addr_q  [CHANNELS];
  word_t cur_addr_d  [CHANNELS];
  word_t base_cnt_q  [CHANNELS];
  word_t base_cnt_d  [CHANNELS];
  word_t cur_cnt_q   [CHANNELS];
  word_t cur_cnt_d   [CHANNELS];

  logic                 ptr_q, ptr_d;
  logic [CHANNELS-1:0]  status_tc_q, status_tc_d;
  logic [DATAWIDTH-1:0] data_out_q, data_out_d;
  logic                 tc_pulse_q, tc_pulse_d;
  logic [1:0]           tc_channel_q, tc_channel_d;

  logic       wr_en, rd_en, chan_sel, status_clr;
  logic [1:0] acc_ch;
  word_t      step_addr;

  function automatic word_t merge_byte(word_t old, logic [DATAWIDTH-1:0] b, logic hi);
    return hi ? {b[HI-1:0], old[DATAWIDTH-1:0]} : {old[ADDRESSWIDTH-1:DATAWIDTH], b};
  endfunction

  function automatic logic [DATAWIDTH-1:0] pick_byte(word_t w, logic hi);
    return hi ? DATAWIDTH'(w >> DATAWIDTH) : w[DATAWIDTH-1:0];
  endfunction

  always_comb begin
    base_addr_d  = base_addr_q;
    cur_addr_d   = cur_addr_q;
    base_cnt_d   = base_cnt_q;
    cur_cnt_d    = cur_cnt_q;
    ptr_d        = ptr_q;
    status_tc_d  = status_tc_q;
    data_out_d   = data_out_q;
    tc_pulse_d   = 1'b0;
    tc_channel_d = tc_channel_q;
    status_clr   = 1'b0;
    wr_en        = cpuWrite;
    rd_en        = cpuRead & ~cpuWrite;
    chan_sel     = ~cpuAddr[3];
    acc_ch       = cpuAddr[2:1];
    step_addr    = addrDecrement[xferChannel] ? cur_addr_q[xferChannel] - ONE
                                              : cur_addr_q[xferChannel] + ONE;

    if (xferStep) begin
      if (cur_cnt_q[xferChannel] == '0) begin
        tc_pulse_d   = 1'b1;
        tc_channel_d = xferChannel;
      end
      if (tc_pulse_d && autoinit[xferChannel]) begin
        cur_addr_d[xferChannel] = base_addr_q[xferChannel];
        cur_cnt_d[xferChannel]  = base_cnt_q[xferChannel];
      end else begin
        cur_addr_d[xferChannel] = step_addr;
        cur_cnt_d[xferChannel]  = cur_cnt_q[xferChannel] - ONE;
      end
    end

    // A CPU write overrides the whole register the step touched, merged against its pre-step value.
    if (wr_en) begin
      if (chan_sel) begin
        if (cpuAddr[0]) begin
          base_cnt_d[acc_ch] = merge_byte(base_cnt_q[acc_ch], dataIn, ptr_q);
          cur_cnt_d[acc_ch]  = merge_byte(cur_cnt_q[acc_ch], dataIn, ptr_q);
        end else begin
          base_addr_d[acc_ch] = merge_byte(base_addr_q[acc_ch], dataIn, ptr_q);
          cur_addr_d[acc_ch]  = merge_byte(cur_addr_q[acc_ch], dataIn, ptr_q);
        end
        ptr_d = ~ptr_q;
      end else if (cpuAddr == ADDR_CLR_PTR) begin
        ptr_d = 1'b0;
      end else if (cpuAddr == ADDR_MASTER_CLR) begin
        ptr_d      = 1'b0;
        status_clr = 1'b1;
      end
    end else if (rd_en) begin
      if (chan_sel) begin
        data_out_d = pick_byte(cpuAddr[0] ? cur_cnt_q[acc_ch] : cur_addr_q[acc_ch], ptr_q);
        ptr_d      = ~ptr_q;
      end else if (cpuAddr == ADDR_STATUS) begin
        data_out_d = DATAWIDTH'({dreqStatus, status_tc_q});
        status_clr = 1'b1;
      end else begin
        data_out_d = '0;
      end
    end

    if (status_clr) status_tc_d = '0;
    if (tc_pulse_d) status_tc_d[xferChannel] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      base_addr_q  <= '{default: '0};
      cur_addr_q   <= '{default: '0};
      base_cnt_q   <= '{default: '0};
      cur_cnt_q    <= '{default: '0};
      ptr_q        <= 1'b0;
      status_tc_q  <= '0;
      data_out_q   <= '0;
      tc_pulse_q   <= 1'b0;
      tc_channel_q <= '0;
    end else begin
      base_addr_q  <= base_addr_d;
      cur_addr_q   <= cur_addr_d;
      base_cnt_q   <= base_cnt_d;
      cur_cnt_q    <= cur_cnt_d;
      ptr_q        <= ptr_d;
      status_tc_q  <= status_tc_d;
      data_out_q   <= data_out_d;
      tc_pulse_q   <= tc_pulse_d;
      tc_channel_q <= tc_channel_d;
    end
  end

  assign currentAddressOut = cur_addr_q[xferChannel];
  assign dataOut           = data_out_q;
  assign tcPulse           = tc_pulse_q;
  assign tcChannel         = tc_channel_q;
  assign statusTC          = status_tc_q;

endmodule
